// File: rtl/moving_average_ctrl_pkg.sv
// Shared types for the moving-average sequencer.
// MOVING_AVERAGE_FLUSH_EN selects whether a zero-writing FLUSH phase precedes FILL.
package moving_average_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

`ifdef MOVING_AVERAGE_FLUSH_EN
  localparam bit     FLUSH_EN    = 1'b1;
  localparam state_t RESET_STATE = FLUSH;
`else
  localparam bit     FLUSH_EN    = 1'b0;
  localparam state_t RESET_STATE = FILL;
`endif

endpackage

// File: rtl/moving_average_ptr.sv
// Wrapping address counter: counts 0..limit_i, then returns to 0 with wrap_o high.
// Shared by the circular delay-line pointer and the FLUSH address.
module moving_average_ptr #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [AW-1:0] limit_i,
  output logic [AW-1:0] ptr_o,
  output logic          wrap_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    wrap_o = en_i && (ptr_q == limit_i);
    ptr_d  = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = wrap_o ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/moving_average_ctrl.sv
// Moving-average sequencer: delay-line addressing, accumulator strobes, window reconfig.
// MOVING_AVERAGE_FLUSH_EN adds a FLUSH phase that zero-fills the active window.
module moving_average_ctrl
  import moving_average_ctrl_pkg::*;
#(
  parameter  int unsigned SIZE_MAX_WINDOW      = 64,
  parameter  int unsigned SIZE_WINDOW          = 8,
  localparam int unsigned SIZE_LOG2_MAX_WINDOW = $clog2(SIZE_MAX_WINDOW),
  localparam int unsigned DEFAULT_LOG2_WINDOW  = $clog2(SIZE_WINDOW),
  localparam int unsigned LW                   = $clog2(SIZE_LOG2_MAX_WINDOW + 1),
  localparam int unsigned AW                   = SIZE_LOG2_MAX_WINDOW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [LW-1:0] cfg_log2_window,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dl_rd_en,
  output logic [AW-1:0] dl_rd_addr,
  output logic          dl_wr_en,
  output logic [AW-1:0] dl_wr_addr,
  output logic          dl_wr_zero,
  output logic          acc_clear,
  output logic          acc_en,
  output logic          acc_sub_en,
  output logic [LW-1:0] shift,
  output logic          out_valid,
  output logic          primed
);

  state_t        state_q, state_d;
  logic [LW-1:0] k_q, k_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;

  logic          s1_valid_q, s1_full_q, s1_sub_q;
  logic [AW-1:0] s1_addr_q;
  logic          s2_valid_q;
  logic          out_valid_q;
  logic          acc_clear_q;

  logic          active, flushing;
  logic          cfg_acc, smp_acc, smp_full, smp_sub;
  logic [AW-1:0] limit;
  logic [AW-1:0] ptr;
  logic          ptr_wrap;

  // One counter serves both phases: FLUSH never accepts samples, so enables never collide.
  moving_average_ptr #(
    .AW(AW)
  ) u_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (cfg_acc),
    .en_i   (smp_acc || flushing),
    .limit_i(limit),
    .ptr_o  (ptr),
    .wrap_o (ptr_wrap)
  );

  always_comb begin
    limit     = AW'((32'd1 << k_q) - 32'd1);
    active    = reset_n && ((state_q == FILL) || (state_q == RUN));
    flushing  = FLUSH_EN && reset_n && (state_q == FLUSH);
    in_ready  = active && !cfg_valid;
    cfg_ready = active && !s1_valid_q && !s2_valid_q;
    cfg_acc   = cfg_valid && cfg_ready;
    smp_acc   = in_valid && in_ready;
    smp_full  = (state_q == RUN) || (fill_cnt_q == limit);
    smp_sub   = FLUSH_EN || (state_q == RUN);
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    fill_cnt_d = fill_cnt_q;
    if (cfg_acc) begin
      k_d        = (cfg_log2_window > LW'(SIZE_LOG2_MAX_WINDOW)) ?
                   LW'(SIZE_LOG2_MAX_WINDOW) : cfg_log2_window;
      fill_cnt_d = '0;
      state_d    = RESET_STATE;
    end else if (flushing && ptr_wrap) begin
      state_d = FILL;
    end else if (smp_acc && (state_q == FILL)) begin
      fill_cnt_d = fill_cnt_q + AW'(1);
      if (fill_cnt_q == limit) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      k_q         <= LW'(DEFAULT_LOG2_WINDOW);
      fill_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_full_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_addr_q   <= '0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fill_cnt_q  <= fill_cnt_d;
      s1_valid_q  <= smp_acc;
      s1_full_q   <= smp_acc && smp_full;
      s1_sub_q    <= smp_acc && smp_sub;
      s1_addr_q   <= ptr;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s1_valid_q && s1_full_q;
      acc_clear_q <= cfg_acc;
    end
  end

  always_comb begin
    dl_rd_en   = smp_acc;
    dl_rd_addr = ptr;
    dl_wr_en   = s1_valid_q || flushing;
    dl_wr_addr = flushing ? ptr : s1_addr_q;
    dl_wr_zero = flushing;
    acc_clear  = acc_clear_q;
    acc_en     = s1_valid_q;
    acc_sub_en = s1_valid_q && s1_sub_q;
    shift      = k_q;
    out_valid  = out_valid_q;
    primed     = (state_q == RUN);
  end

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Directed bench for moving_average_ctrl; follows MOVING_AVERAGE_FLUSH_EN if defined.
module tb_moving_average_ctrl;

  localparam int unsigned LW = 3;
  localparam int unsigned AW = 6;
`ifdef MOVING_AVERAGE_FLUSH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_log2_window;
  logic          in_valid;
  logic          in_ready;
  logic          dl_rd_en;
  logic [AW-1:0] dl_rd_addr;
  logic          dl_wr_en;
  logic [AW-1:0] dl_wr_addr;
  logic          dl_wr_zero;
  logic          acc_clear;
  logic          acc_en;
  logic          acc_sub_en;
  logic [LW-1:0] shift;
  logic          out_valid;
  logic          primed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  moving_average_ctrl #(
    .SIZE_MAX_WINDOW(64),
    .SIZE_WINDOW    (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_log2_window(cfg_log2_window),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dl_rd_en       (dl_rd_en),
    .dl_rd_addr     (dl_rd_addr),
    .dl_wr_en       (dl_wr_en),
    .dl_wr_addr     (dl_wr_addr),
    .dl_wr_zero     (dl_wr_zero),
    .acc_clear      (acc_clear),
    .acc_en         (acc_en),
    .acc_sub_en     (acc_sub_en),
    .shift          (shift),
    .out_valid      (out_valid),
    .primed         (primed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

`ifdef MOVING_AVERAGE_FLUSH_EN
  task automatic flush_check(input int unsigned n);
    for (int unsigned j = 0; j < n; j++) begin
      settle();
      check("flush_wr_en", 32'(dl_wr_en), 32'd1);
      check("flush_addr", 32'(dl_wr_addr), j);
      check("flush_zero", 32'(dl_wr_zero), 32'd1);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      next();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_log2_window = '0; in_valid = 1'b0;
    next(); next();

    // First cycle after reset.
    reset_n = 1'b1;
    settle();
    check("rst_acc_clear", 32'(acc_clear), 32'd1);
    check("rst_shift", 32'(shift), 32'd3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    check("rst_acc_en", 32'(acc_en), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'(!FE));
    check("rst_wr_zero", 32'(dl_wr_zero), 32'(FE));
`ifdef MOVING_AVERAGE_FLUSH_EN
    flush_check(8);
`else
    next();
`endif
    settle();
    check("clear_pulse", 32'(acc_clear), 32'd0);
    check("fill_in_ready", 32'(in_ready), 32'd1);

    // Continuous stream from empty, W=8: primes on the 8th accept.
    for (int unsigned i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      settle();
      check("ramp_rd_en", 32'(dl_rd_en), 32'd1);
      check("ramp_rd_addr", 32'(dl_rd_addr), i % 8);
      check("ramp_acc_en", 32'(acc_en), 32'(i >= 1));
      check("ramp_wr_en", 32'(dl_wr_en), 32'(i >= 1));
      if (i >= 1) check("ramp_wr_addr", 32'(dl_wr_addr), (i - 1) % 8);
      check("ramp_sub", 32'(acc_sub_en), 32'(FE ? (i >= 1) : (i >= 9)));
      check("ramp_out_valid", 32'(out_valid), 32'(i >= 9));
      check("ramp_primed", 32'(primed), 32'(i >= 8));
      next();
    end

    // Config request collides with a sample, then waits for drain.
    cfg_valid = 1'b1; cfg_log2_window = 3'd2; in_valid = 1'b1;
    settle();
    check("cfg_in_ready", 32'(in_ready), 32'd0);
    check("cfg_rd_en", 32'(dl_rd_en), 32'd0);
    check("drain0_cfg_ready", 32'(cfg_ready), 32'd0);
    check("drain0_out_valid", 32'(out_valid), 32'd1);
    next(); settle();
    check("drain1_cfg_ready", 32'(cfg_ready), 32'd0);
    check("drain1_out_valid", 32'(out_valid), 32'd1);
    next(); settle();
    check("drain2_cfg_ready", 32'(cfg_ready), 32'd1);
    check("drain2_shift", 32'(shift), 32'd3);
    check("drain2_out_valid", 32'(out_valid), 32'd0);
    next();
    cfg_valid = 1'b0; in_valid = 1'b0;
    settle();
    check("k2_shift", 32'(shift), 32'd2);
    check("k2_acc_clear", 32'(acc_clear), 32'd1);
    check("k2_primed", 32'(primed), 32'd0);
`ifdef MOVING_AVERAGE_FLUSH_EN
    flush_check(4);
`else
    next();
`endif
    settle();
    check("k2_in_ready", 32'(in_ready), 32'd1);

    // W=1: every sample is a full window, address never moves.
    cfg_valid = 1'b1; cfg_log2_window = 3'd0;
    settle();
    check("k0_cfg_ready", 32'(cfg_ready), 32'd1);
    next();
    cfg_valid = 1'b0;
    settle();
    check("k0_shift", 32'(shift), 32'd0);
`ifdef MOVING_AVERAGE_FLUSH_EN
    flush_check(1);
`else
    next();
`endif
    in_valid = 1'b1;
    settle();
    check("k0_rd_addr_a", 32'(dl_rd_addr), 32'd0);
    check("k0_rd_en_a", 32'(dl_rd_en), 32'd1);
    next(); settle();
    check("k0_rd_addr_b", 32'(dl_rd_addr), 32'd0);
    check("k0_primed", 32'(primed), 32'd1);
    next();
    in_valid = 1'b0;
    settle();
    check("k0_out_a", 32'(out_valid), 32'd1);
    next(); settle();
    check("k0_out_b", 32'(out_valid), 32'd1);
    next(); settle();
    check("k0_out_c", 32'(out_valid), 32'd0);

    // Oversized request is clamped to the maximum window.
    cfg_valid = 1'b1; cfg_log2_window = 3'd7;
    settle();
    check("clamp_cfg_ready", 32'(cfg_ready), 32'd1);
    next();
    cfg_valid = 1'b0;
    settle();
    check("clamp_shift", 32'(shift), 32'd6);
`ifdef MOVING_AVERAGE_FLUSH_EN
    flush_check(64);
`else
    next();
`endif
    for (int unsigned i = 0; i < 70; i++) begin
      in_valid = 1'b1;
      settle();
      check("w64_rd_addr", 32'(dl_rd_addr), i % 64);
      check("w64_primed", 32'(primed), 32'(i >= 64));
      check("w64_out_valid", 32'(out_valid), 32'(i >= 65));
      next();
    end

    // Reset mid-stream: in-flight samples must not surface.
    reset_n = 1'b0;
    settle();
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_rd_en", 32'(dl_rd_en), 32'd0);
    next();
    reset_n = 1'b1; in_valid = 1'b0;
    settle();
    check("mrst_acc_clear", 32'(acc_clear), 32'd1);
    check("mrst_shift", 32'(shift), 32'd3);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_primed", 32'(primed), 32'd0);
    check("mrst_acc_en", 32'(acc_en), 32'd0);
`ifdef MOVING_AVERAGE_FLUSH_EN
    flush_check(8);
`else
    next();
`endif
    for (int unsigned i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      settle();
      check("post_sub", 32'(acc_sub_en), 32'(FE ? (i >= 1) : (i >= 9)));
      check("post_out_valid", 32'(out_valid), 32'(i >= 9));
      check("post_rd_addr", 32'(dl_rd_addr), i % 8);
      next();
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
